usb_tx_encoder: RTL and testbench
=================================

// Module: usb_tx_encoder
// PURPOSE
//  Downstream serial stage of the USB transmit path. Accepts bytes from the tx control FSM (data_pts/load_enable).
//  Serialises them LSB-first at 12 Mbit/s from a 100 MHz clock (25/3 clocks per bit).
//  Performs bit stuffing and NRZI encoding, and drives dplus/dminus, including SE0 for EOP.
//  Returns the byte-done flag and per-bit shift_strobe that the FSM sequences on.
// PARAMETERS
//  STUFF_LIMIT  6   consecutive 1 data bits after which a stuffed 0 is inserted
//  BIT_CLKS_S   8   short bit period, in clocks
//  BIT_CLKS_L   9   long bit period, in clocks; the period pattern is S,S,L repeating (25 clocks per 3 bits)
// PORTS
//  clk           in   1  system clock, 100 MHz
//  n_rst         in   1  asynchronous reset, active low
//  enable_timer  in   1  bit timer runs while high
//  clear_timer   in   1  synchronous: timer count and S,S,L phase return to 0; wins over enable_timer
//  load_enable   in   1  write data_pts into the holding register this cycle
//  data_pts      in   8  byte to transmit, sent LSB first
//  state_val     in   3  FSM state code: 0 idle, 1 pid, 2 sync, 3 data, 4 crc_hi, 5 crc_lo, 6 eop1, 7 eop2
//  shift_strobe  out  1  one-cycle pulse at the end of every bit period, including stuffed bits and SE0 bits
//  flag          out  1  one-cycle pulse when the 8th data bit of the current byte completes
//  dplus         out  1  USB D+ line
//  dminus        out  1  USB D- line
// BEHAVIOUR
//  Reset: all outputs and state reset asynchronously.
//   - dplus=1, dminus=0 (J); shift_strobe=0; flag=0.
//   - ones_cnt=0, bit_cnt=0, shifter and holding register empty, NRZI level=J.
//  Bit timer:
//   - Counts while enable_timer=1 and clear_timer=0.
//   - shift_strobe is registered. It asserts on the last clock of each period and the count wraps to 0.
//   - Period phase cycles S,S,L. clear_timer resets the phase to the first S.
//  Buffering:
//   - 8-bit holding register plus an 8-bit shifter.
//   - load_enable overwrites the holding register. Any load before transfer replaces the earlier one; last write wins.
//   - Holding moves into the shifter when the shifter is empty, either immediately or at a byte boundary, then clears.
//   - If shifter and holding are both empty at a byte boundary, the shifter stays empty and the line holds its NRZI level.
//  Per shift_strobe, when state_val is 1..5 and the shifter holds a byte:
//   - If ones_cnt==STUFF_LIMIT: send stuffed 0. The line toggles, ones_cnt=0, the shifter does not advance, bit_cnt is unchanged.
//   - Else send shifter[0]:
//     - 0: line toggles, ones_cnt=0.
//     - 1: line holds, ones_cnt+1.
//     - Then shift right and increment bit_cnt.
//   - When bit_cnt wraps 7->0, flag pulses in the cycle after the strobe.
//  Stuffing across boundaries: ones_cnt persists across byte boundaries. A stuff bit pending at a byte end is sent before the next byte's bit 0.
//  Line outputs:
//   - dplus/dminus are registered; they change in the cycle after shift_strobe.
//   - NRZI: J=(1,0), K=(0,1).
//  state_val 6 or 7 (EOP):
//   - Drive SE0 (0,0) from the next strobe.
//   - Clear ones_cnt, bit_cnt, shifter and holding register. flag is not produced.
//  state_val 0:
//   - Drive J; NRZI level=J; ones_cnt=0.
//   - Line changes immediately, without waiting for a strobe.
//  Simultaneous events:
//   - load_enable in the same cycle as a byte-boundary transfer: the new byte lands in holding, and the old holding byte moves to the shifter.
//   - clear_timer in the same cycle as a strobe: the strobe is still emitted.
//  Reset mid-byte: the line returns asynchronously to J and the partial byte is discarded.
// STRUCTURE
//  Package usb_tx_pkg:
//   - state_val code localparams: TXS_IDLE=0 .. TXS_EOP2=7.
//   - Line constants: LINE_J=2'b10, LINE_K=2'b01, LINE_SE0=2'b00.
//   - STUFF_LIMIT default.
//  Sub-module usb_bit_timer: S,S,L period counter with enable/clear, output strobe.
//  Top level: holding register, shifter, stuff/NRZI logic, line register.
// TESTING
//  1 Reset asserted -> dplus=1, dminus=0, flag=0, shift_strobe=0 asynchronously.
//  2 enable_timer=1 for 75 clocks -> strobe intervals 8,8,9 repeating; 9 strobes total.
//  3 clear_timer pulsed mid-period, then run -> next strobe 8 clocks after the clear.
//  4 load 0x80 with state_val=2 from J -> line K,J,K,J,K,J,K,K; flag pulses 1 clock after the 66th clock's strobe.
//  5 load 0xFF then 0xFF, state_val=3 -> after 6 ones the line toggles for a stuff bit; first flag arrives one bit period late (75 clocks).
//  6 state_val 6 then 7 over two strobes -> SE0 for two bits; state_val 0 -> J; next byte starts with ones_cnt=0.
//  7 n_rst pulsed mid-byte -> immediate J; a fresh load of 0x00 -> 8 toggles, flag after 66 clocks.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared constants and types for the USB transmit encoder.
//   TXS_*       state_val codes driven by the tx control FSM
//   LINE_*      {dplus, dminus} line encodings
//   STUFF_LIMIT run of 1 data bits after which a 0 is stuffed
//   BIT_CLKS_*  short/long bit periods; the S,S,L pattern gives 25 clocks per 3 bits
package usb_tx_pkg;

    localparam logic [2:0] TXS_IDLE   = 3'd0;
    localparam logic [2:0] TXS_PID    = 3'd1;
    localparam logic [2:0] TXS_SYNC   = 3'd2;
    localparam logic [2:0] TXS_DATA   = 3'd3;
    localparam logic [2:0] TXS_CRC_HI = 3'd4;
    localparam logic [2:0] TXS_CRC_LO = 3'd5;
    localparam logic [2:0] TXS_EOP1   = 3'd6;
    localparam logic [2:0] TXS_EOP2   = 3'd7;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int STUFF_LIMIT = 6;
    localparam int BIT_CLKS_S  = 8;
    localparam int BIT_CLKS_L  = 9;

    typedef enum logic [1:0] {PH_S0, PH_S1, PH_L} bit_phase_e;

    function automatic logic is_data_state(input logic [2:0] s);
        return s >= TXS_PID && s <= TXS_CRC_LO;
    endfunction

endpackage

// File: rtl/usb_tx_if.sv
// usb_tx_if: control/handshake bundle between the tx control FSM and the encoder.
//   enable_timer, clear_timer  bit timer control (FSM -> encoder)
//   load_enable, data_pts      byte write into the holding register (FSM -> encoder)
//   state_val                  current FSM state code (FSM -> encoder)
//   shift_strobe, flag         per-bit strobe and byte-done pulse (encoder -> FSM)
interface usb_tx_if;

    logic       enable_timer;
    logic       clear_timer;
    logic       load_enable;
    logic [7:0] data_pts;
    logic [2:0] state_val;
    logic       shift_strobe;
    logic       flag;

    modport master (
        output enable_timer, clear_timer, load_enable, data_pts, state_val,
        input  shift_strobe, flag
    );

    modport slave (
        input  enable_timer, clear_timer, load_enable, data_pts, state_val,
        output shift_strobe, flag
    );

endinterface

// File: rtl/usb_bit_timer.sv
// usb_bit_timer: 12 Mbit/s bit period generator from a 100 MHz clock.
//   clk, n_rst     clock, asynchronous active-low reset
//   enable_timer   count while high
//   clear_timer    return count and S,S,L phase to the start; wins over enable
//   shift_strobe   registered one-cycle pulse at the end of each bit period
module usb_bit_timer import usb_tx_pkg::*; #(
    parameter int CLKS_S = BIT_CLKS_S,
    parameter int CLKS_L = BIT_CLKS_L
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable_timer,
    input  logic clear_timer,
    output logic shift_strobe
);

    bit_phase_e phase, phase_nxt;
    logic [3:0] count, count_nxt;
    logic       last;

    always_comb begin
        last      = count == 4'((phase == PH_L ? CLKS_L : CLKS_S) - 1);
        phase_nxt = phase;
        count_nxt = count;
        if (clear_timer) begin
            phase_nxt = PH_S0;
            count_nxt = '0;
        end else if (enable_timer) begin
            count_nxt = last ? 4'd0 : count + 4'd1;
            if (last)
                phase_nxt = (phase == PH_S0) ? PH_S1 : (phase == PH_S1) ? PH_L : PH_S0;
        end
    end

    // A strobe due on the clearing cycle is still emitted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase        <= PH_S0;
            count        <= '0;
            shift_strobe <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            count        <= count_nxt;
            shift_strobe <= enable_timer && last;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: byte buffering, LSB-first serialisation, bit stuffing and NRZI line drive.
//   clk, n_rst       clock, asynchronous active-low reset
//   bus (slave)      timer control, byte load, state code in; shift_strobe, flag out
//   dplus, dminus    registered USB line outputs (J=10, K=01, SE0=00)
module usb_tx_encoder import usb_tx_pkg::*; (
    input  logic    clk,
    input  logic    n_rst,
    usb_tx_if.slave bus,
    output logic    dplus,
    output logic    dminus
);

    logic       strobe, flag_r, flag_n;
    logic [1:0] line, line_n;
    logic       lvl, lvl_n;
    logic [2:0] ones, ones_n, bit_cnt, bit_cnt_n;
    logic [7:0] shifter, shifter_n, hold, hold_n;
    logic       sh_valid, sh_valid_n, hold_valid, hold_valid_n;
    logic       idle, eop, data_st, stuff, send, shift, boundary, take, toggle;

    usb_bit_timer u_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (bus.enable_timer),
        .clear_timer  (bus.clear_timer),
        .shift_strobe (strobe)
    );

    assign bus.shift_strobe = strobe;
    assign bus.flag         = flag_r;
    assign {dplus, dminus}  = line;

    always_comb begin
        idle     = bus.state_val == TXS_IDLE;
        eop      = bus.state_val == TXS_EOP1 || bus.state_val == TXS_EOP2;
        data_st  = is_data_state(bus.state_val);
        stuff    = ones == 3'(STUFF_LIMIT);
        send     = strobe && data_st && sh_valid;
        // A pending stuff bit consumes the strobe without advancing the shifter.
        shift    = send && !stuff;
        boundary = shift && bit_cnt == 3'd7;
        // Holding refills the shifter whenever it is, or is about to become, empty.
        take     = !eop && hold_valid && (!sh_valid || boundary);
        toggle   = send && (stuff || !shifter[0]);
        lvl_n        = idle ? 1'b1 : lvl ^ toggle;
        ones_n       = (idle || eop || toggle) ? 3'd0 : shift ? ones + 3'd1 : ones;
        bit_cnt_n    = eop ? 3'd0 : shift ? bit_cnt + 3'd1 : bit_cnt;
        shifter_n    = eop ? 8'd0 : take ? hold : shift ? shifter >> 1 : shifter;
        sh_valid_n   = eop ? 1'b0 : take ? 1'b1 : boundary ? 1'b0 : sh_valid;
        hold_n       = eop ? 8'd0 : bus.load_enable ? bus.data_pts : hold;
        hold_valid_n = !eop && (bus.load_enable || (hold_valid && !take));
        line_n       = idle ? LINE_J :
                       (eop && strobe) ? LINE_SE0 :
                       (data_st && strobe) ? (lvl_n ? LINE_J : LINE_K) : line;
        flag_n       = boundary;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line       <= LINE_J;
            lvl        <= 1'b1;
            ones       <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
            sh_valid   <= 1'b0;
            hold       <= '0;
            hold_valid <= 1'b0;
            flag_r     <= 1'b0;
        end else begin
            line       <= line_n;
            lvl        <= lvl_n;
            ones       <= ones_n;
            bit_cnt    <= bit_cnt_n;
            shifter    <= shifter_n;
            sh_valid   <= sh_valid_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
            flag_r     <= flag_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: scoreboard bench for usb_tx_encoder with a bit-stream reference model.
module tb_usb_tx_encoder;

    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;

    typedef struct {
        int         t;
        logic [1:0] line;
        logic       flag;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic dplus, dminus;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [7:0] bq[$];
    bit   m_j = 1'b1;
    int   m_ones = 0;

    usb_tx_if bus();

    usb_tx_encoder dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .bus    (bus),
        .dplus  (dplus),
        .dminus (dminus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the cycle after every strobe, pop one expectation and compare.
    bit post = 1'b0;
    int st_t = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!n_rst) post = 1'b0;
        else begin
            checks++;
            if (post) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe at cycle %0d", st_t);
                end else begin
                    e = exp_q.pop_front();
                    if (st_t != e.t || {dplus, dminus} != e.line || bus.flag != e.flag) begin
                        errors++;
                        $display("FAIL bit_out got t=%0d line=%b flag=%b exp t=%0d line=%b flag=%b",
                                 st_t, {dplus, dminus}, bus.flag, e.t, e.line, e.flag);
                    end
                end
            end else if (bus.flag) begin
                errors++;
                $display("FAIL stray_flag at cycle %0d got 1 exp 0", cyc);
            end
            post = bus.shift_strobe;
            st_t = cyc;
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] b);
        bus.data_pts    = b;
        bus.load_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.load_enable = 1'b0;
    endtask

    task automatic start_timer(output int t0);
        bus.clear_timer  = 1'b1;
        bus.enable_timer = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.clear_timer  = 1'b0;
        bus.enable_timer = 1'b1;
    endtask

    task automatic push(input int t, input logic [1:0] line, input logic flag);
        exp_t e;
        e.t = t;
        e.line = line;
        e.flag = flag;
        exp_q.push_back(e);
    endtask

    task automatic wait_empty();
        int k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout got %0d pending exp 0", exp_q.size());
            exp_q.delete();
        end
        bus.enable_timer = 1'b0;
    endtask

    // Reference: expand bq into the on-wire bit stream (stuffing, NRZI), then
    // schedule one expectation per strobe; strobe k lands floor(25k/3) clocks in.
    task automatic plan_data(input int t0, input int extra, output int end0);
        bit lv[$];
        bit fl[$];
        bit cur;
        logic [7:0] b;
        cur = m_j;
        end0 = 0;
        foreach (bq[i]) begin
            b = bq[i];
            for (int j = 0; j < 8; j++) begin
                if (m_ones == 6) begin
                    m_j = !m_j;
                    m_ones = 0;
                    lv.push_back(m_j);
                    fl.push_back(1'b0);
                end
                if (b[j]) m_ones++;
                else begin
                    m_j = !m_j;
                    m_ones = 0;
                end
                lv.push_back(m_j);
                fl.push_back(j == 7);
                if (j == 7 && i == 0) end0 = lv.size();
            end
        end
        for (int k = 1; k <= lv.size() + extra; k++) begin
            if (k <= lv.size()) cur = lv[k-1];
            push(t0 + (25 * k) / 3, cur ? J : K, k <= lv.size() ? fl[k-1] : 1'b0);
        end
    endtask

    task automatic run_data(input logic [2:0] st, input int extra, input bit mid, input bit lww);
        int t0, e0;
        logic [7:0] mb;
        bus.state_val = st;
        if (bq.size() > 0) load(bq[0]);
        if (bq.size() > 1) begin
            if (lww) load(8'($urandom));
            load(bq[1]);
        end
        mb = 8'($urandom);
        if (mid && bq.size() == 2) bq.push_back(mb);
        start_timer(t0);
        plan_data(t0, extra, e0);
        if (bq.size() == 3) begin
            wait_edge(t0 + (25 * e0) / 3);
            load(mb);
        end
        wait_empty();
    endtask

    task automatic eop_session();
        int t0;
        bus.state_val = 3'd6;
        load(8'($urandom));
        start_timer(t0);
        push(t0 + 8, SE0, 1'b0);
        push(t0 + 16, SE0, 1'b0);
        wait_edge(t0 + 9);
        bus.state_val = 3'd7;
        wait_empty();
        m_ones = 0;
    endtask

    task automatic idle_session();
        bus.state_val = 3'd0;
        @(posedge clk);
        #1;
        check("idle_line", {2'b00, dplus, dminus}, {2'b00, J});
        m_j = 1'b1;
        m_ones = 0;
    endtask

    initial begin
        int t0, tc;
        bus.enable_timer = 1'b0;
        bus.clear_timer  = 1'b0;
        bus.load_enable  = 1'b0;
        bus.data_pts     = 8'h00;
        bus.state_val    = 3'd0;

        #3 n_rst = 1'b0;
        #1 check("reset_out", {dplus, dminus, bus.flag, bus.shift_strobe}, 4'b1000);
        @(posedge clk);
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;

        start_timer(t0);
        for (int k = 1; k <= 9; k++) push(t0 + (25 * k) / 3, J, 1'b0);
        wait_empty();

        start_timer(t0);
        for (int k = 1; k <= 4; k++) push(t0 + (25 * k) / 3, J, 1'b0);
        tc = t0 + 36;
        for (int k = 1; k <= 4; k++) push(tc + (25 * k) / 3, J, 1'b0);
        push(tc + 33 + 8, J, 1'b0);
        wait_edge(tc - 1);
        bus.clear_timer = 1'b1;
        wait_edge(tc);
        bus.clear_timer = 1'b0;
        wait_edge(tc + 32);
        bus.clear_timer = 1'b1;
        wait_edge(tc + 33);
        bus.clear_timer = 1'b0;
        wait_empty();

        idle_session();
        bq = '{8'h80};
        run_data(3'd2, 1, 1'b0, 1'b0);

        bq = '{8'hFF, 8'hFF};
        run_data(3'd3, 2, 1'b0, 1'b0);

        eop_session();
        idle_session();
        bq.delete();
        run_data(3'd3, 2, 1'b0, 1'b0);
        bq = '{8'hFF};
        run_data(3'd3, 1, 1'b0, 1'b0);

        bq = '{8'h5A, 8'hC3};
        bus.state_val = 3'd3;
        load(bq[0]);
        load(bq[1]);
        start_timer(t0);
        plan_data(t0, 0, tc);
        wait_edge(t0 + 30);
        #2 n_rst = 1'b0;
        exp_q.delete();
        #1 check("midbyte_reset", {dplus, dminus, bus.flag, bus.shift_strobe}, 4'b1000);
        bus.enable_timer = 1'b0;
        m_j = 1'b1;
        m_ones = 0;
        #4 n_rst = 1'b1;
        @(posedge clk);
        #1;
        bq = '{8'h00};
        run_data(3'd3, 1, 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            int nb;
            logic [7:0] b;
            nb = $urandom_range(0, 2);
            bq.delete();
            repeat (nb) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) b = b | 8'($urandom);
                bq.push_back(b);
            end
            run_data(3'($urandom_range(1, 5)), $urandom_range(0, 3),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                eop_session();
                idle_session();
            end
        end
        idle_session();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
